if_bpu: RTL and testbench

IF_BPU -- requirements
Module: if_bpu

---
 rtl/if_bpu_pkg.sv | 32 +++
 rtl/if_bpu_bht.sv | 37 +++
 rtl/if_bpu.sv | 145 ++++++++++++++
 tb/tb_if_bpu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_bpu_pkg.sv
`default_nettype none
//==============================================================================
// Module : if_bpu_pkg
// Brief  : Shared opcodes, link registers and defaults for the fetch predictor.
// Rev    : 1.0  initial release
//==============================================================================
package if_bpu_pkg;

  localparam int          c_XLEN_DEF      = 32;
  localparam int          c_BHT_DEPTH_DEF = 64;
  localparam int          c_RAS_DEPTH_DEF = 4;
  localparam logic [1:0]  c_BHT_INIT_DEF  = 2'b01;

  localparam logic [6:0]  c_OPC_JAL       = 7'b1101111;
  localparam logic [6:0]  c_OPC_JALR      = 7'b1100111;
  localparam logic [6:0]  c_OPC_BRANCH    = 7'b1100011;

  localparam logic [4:0]  c_LINK_RA       = 5'd1;
  localparam logic [4:0]  c_LINK_T0       = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == c_LINK_RA) || (r == c_LINK_T0);
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_bpu_bht.sv
`default_nettype none
//==============================================================================
// Module : if_bpu_bht
// Brief  : Table of 2-bit branch counters, one read port and one update port.
// Rev    : 1.0  initial release
//==============================================================================
module if_bpu_bht
  import if_bpu_pkg::*;
#(
  parameter int         BHT_DEPTH = c_BHT_DEPTH_DEF,
  parameter logic [1:0] BHT_INIT  = c_BHT_INIT_DEF,
  parameter int         IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [1:0] r_cnt [BHT_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= BHT_INIT;
    end else if (i_wr_en) begin
      r_cnt[i_wr_idx] <= ctr_update(r_cnt[i_wr_idx], i_wr_taken);
    end
  end

  // Read sees the pre-update value when both ports hit one entry.
  assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/if_bpu.sv
`default_nettype none
//==============================================================================
// Module : if_bpu
// Brief  : Same-cycle fetch predictor: pre-decode, counter table, return stack.
// Rev    : 1.0  initial release
//==============================================================================
module if_bpu
  import if_bpu_pkg::*;
#(
  parameter int         XLEN      = c_XLEN_DEF,
  parameter int         BHT_DEPTH = c_BHT_DEPTH_DEF,
  parameter int         RAS_DEPTH = c_RAS_DEPTH_DEF,
  parameter logic [1:0] BHT_INIT  = c_BHT_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid_i,
  input  logic            if_stall_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_instr_i,
  input  logic            flush_i,
  input  logic            ex_upd_valid_i,
  input  logic [XLEN-1:0] ex_upd_pc_i,
  input  logic            ex_upd_taken_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            pred_is_branch_o
);

  localparam int c_IDX_W = $clog2(BHT_DEPTH);
  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_RAS_FULL = c_CNT_W'(RAS_DEPTH);

  logic [6:0]         w_opcode;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic               w_is_jal;
  logic               w_is_jalr;
  logic               w_is_br;
  logic               w_call;
  logic               w_ret;
  logic [XLEN-1:0]    w_imm_j;
  logic [XLEN-1:0]    w_imm_b;
  logic [XLEN-1:0]    w_pc_plus4;
  logic [c_IDX_W-1:0] w_bht_idx;
  logic [c_IDX_W-1:0] w_upd_idx;
  logic [1:0]         w_bht_cnt;
  logic               w_unused_pc;

  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ras_ptr;
  logic [c_CNT_W-1:0] r_ras_cnt;
  logic [XLEN-1:0]    w_ras_top;
  logic               w_ras_empty;
  logic               w_spec;
  logic               w_do_push;
  logic               w_do_pop;
  logic [c_PTR_W-1:0] w_ras_waddr;

  assign w_opcode  = if_instr_i[6:0];
  assign w_rd      = if_instr_i[11:7];
  assign w_rs1     = if_instr_i[19:15];
  assign w_is_jal  = (w_opcode == c_OPC_JAL);
  assign w_is_jalr = (w_opcode == c_OPC_JALR);
  assign w_is_br   = (w_opcode == c_OPC_BRANCH);

  assign w_imm_j = {{(XLEN-20){if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                    if_instr_i[30:21], 1'b0};
  assign w_imm_b = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                    if_instr_i[11:8], 1'b0};

  assign w_call = (w_is_jal | w_is_jalr) & is_link(w_rd);
  assign w_ret  = w_is_jalr & is_link(w_rs1) & ~(is_link(w_rd) & (w_rs1 == w_rd));

  assign w_pc_plus4 = if_pc_i + XLEN'(4);
  assign w_bht_idx  = if_pc_i[c_IDX_W+1:2];
  assign w_upd_idx  = ex_upd_pc_i[c_IDX_W+1:2];
  assign w_unused_pc = ^{ex_upd_pc_i[XLEN-1:c_IDX_W+2], ex_upd_pc_i[1:0]};

  if_bpu_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .BHT_INIT  (BHT_INIT),
    .IDX_W     (c_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_bht_idx),
    .o_rd_cnt   (w_bht_cnt),
    .i_wr_en    (ex_upd_valid_i),
    .i_wr_idx   (w_upd_idx),
    .i_wr_taken (ex_upd_taken_i)
  );

  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_top   = r_ras[r_ras_ptr - 1'b1];

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = w_pc_plus4;
    if (if_valid_i) begin
      if (w_is_jal) begin
        pred_taken_o  = 1'b1;
        pred_target_o = if_pc_i + w_imm_j;
      end else if (w_is_br) begin
        if (w_bht_cnt[1]) begin
          pred_taken_o  = 1'b1;
          pred_target_o = if_pc_i + w_imm_b;
        end
      end else if (w_ret && !w_ras_empty) begin
        pred_taken_o  = 1'b1;
        pred_target_o = w_ras_top;
      end
    end
  end

  assign pred_is_branch_o = if_valid_i & w_is_br;

  // Pop-then-push on a combined call/return rewrites the top slot in place.
  assign w_spec      = if_valid_i & ~if_stall_i & ~flush_i;
  assign w_do_push   = w_spec & w_call;
  assign w_do_pop    = w_spec & w_ret & ~w_ras_empty;
  assign w_ras_waddr = w_do_pop ? (r_ras_ptr - 1'b1) : r_ras_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (flush_i) begin
      r_ras_cnt <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_ras_ptr <= r_ras_ptr + 1'b1;
      if (r_ras_cnt != c_RAS_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      r_ras_ptr <= r_ras_ptr - 1'b1;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) r_ras[w_ras_waddr] <= w_pc_plus4;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_bpu.sv
`default_nettype none
//==============================================================================
// Module : tb_if_bpu
// Brief  : Scoreboard bench for if_bpu with a queue-based reference model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_if_bpu;

  localparam int         XLEN      = 32;
  localparam int         BHT_DEPTH = 64;
  localparam int         RAS_DEPTH = 4;
  localparam logic [1:0] BHT_INIT  = 2'b01;

  typedef enum int {K_OTHER, K_JAL, K_JALR, K_BR} kind_t;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic        is_br;
    bit          dir;
    logic        dtaken;
    logic [31:0] dtarget;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_valid_i;
  logic            if_stall_i;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_instr_i;
  logic            flush_i;
  logic            ex_upd_valid_i;
  logic [XLEN-1:0] ex_upd_pc_i;
  logic            ex_upd_taken_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            pred_is_branch_o;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          bht_m[BHT_DEPTH];
  logic [31:0] ras_m[$];

  if_bpu #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH),
    .RAS_DEPTH (RAS_DEPTH),
    .BHT_INIT  (BHT_INIT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid_i       (if_valid_i),
    .if_stall_i       (if_stall_i),
    .if_pc_i          (if_pc_i),
    .if_instr_i       (if_instr_i),
    .flush_i          (flush_i),
    .ex_upd_valid_i   (ex_upd_valid_i),
    .ex_upd_pc_i      (ex_upd_pc_i),
    .ex_upd_taken_i   (ex_upd_taken_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .pred_is_branch_o (pred_is_branch_o)
  );

  always #5 clk = ~clk;

  function automatic logic link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_DEPTH);
  endfunction

  function automatic logic [31:0] mk_instr(input kind_t k, input logic [4:0] rd,
                                           input logic [4:0] rs1, input int imm,
                                           input logic [31:0] r);
    logic [31:0] iv;
    logic [6:0]  op;
    iv = imm;
    case (k)
      K_JAL:  return {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
      K_JALR: return {r[11:0], rs1, 3'b000, rd, 7'b1100111};
      K_BR:   return {iv[12], iv[10:5], r[4:0], rs1, r[7:5], iv[4:1], iv[11], 7'b1100011};
      default: begin
        op = (r[1:0] == 2'd0) ? 7'b0010011 : (r[1:0] == 2'd1) ? 7'b0110011 : 7'b0000011;
        return {r[31:7], op};
      end
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({e.name, "/taken"},  32'(pred_taken_o),     32'(e.taken));
      cmp({e.name, "/target"}, pred_target_o,         e.target);
      cmp({e.name, "/is_br"},  32'(pred_is_branch_o), 32'(e.is_br));
      if (e.dir) begin
        cmp({e.name, "/spec_taken"},  32'(pred_taken_o), 32'(e.dtaken));
        cmp({e.name, "/spec_target"}, pred_target_o,     e.dtarget);
      end
    end
  end

  // One cycle: apply inputs, predict from the model, then advance the model.
  task automatic drive(input logic v, input logic stall, input logic flush,
                       input logic [31:0] pc, input kind_t k, input logic [4:0] rd,
                       input logic [4:0] rs1, input int imm, input logic ev,
                       input logic [31:0] epc, input logic et, input logic rstn,
                       input bit d, input logic dt, input logic [31:0] dtg,
                       input string nm);
    exp_t        e;
    logic [31:0] immv;
    logic        ret;
    logic        call;
    int          i;
    immv = imm;
    ret  = (k == K_JALR) && link(rs1) && !(link(rd) && rs1 == rd);
    call = (k == K_JAL || k == K_JALR) && link(rd);

    rst_n          = rstn;
    if_valid_i     = v;
    if_stall_i     = stall;
    flush_i        = flush;
    if_pc_i        = pc;
    if_instr_i     = mk_instr(k, rd, rs1, imm, $urandom);
    ex_upd_valid_i = ev;
    ex_upd_pc_i    = epc;
    ex_upd_taken_i = et;

    if (rstn) begin
      e.name = nm; e.taken = 1'b0; e.target = pc + 32'd4;
      e.is_br = v && (k == K_BR);
      e.dir = d; e.dtaken = dt; e.dtarget = dtg;
      if (v) begin
        if (k == K_JAL) begin
          e.taken = 1'b1; e.target = pc + immv;
        end else if (k == K_BR) begin
          if (bht_m[idx_of(pc)] >= 2) begin e.taken = 1'b1; e.target = pc + immv; end
        end else if (ret && ras_m.size() > 0) begin
          e.taken = 1'b1; e.target = ras_m[ras_m.size()-1];
        end
      end
      exp_q.push_back(e);
    end

    @(posedge clk);
    if (!rstn) begin
      for (int j = 0; j < BHT_DEPTH; j++) bht_m[j] = int'(BHT_INIT);
      ras_m.delete();
    end else begin
      if (ev) begin
        i = idx_of(epc);
        if (et && bht_m[i] < 3) bht_m[i]++;
        else if (!et && bht_m[i] > 0) bht_m[i]--;
      end
      if (flush) ras_m.delete();
      else if (v && !stall) begin
        if (ret && ras_m.size() > 0) void'(ras_m.pop_back());
        if (call) begin
          ras_m.push_back(pc + 32'd4);
          if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic fetch(input kind_t k, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] rs1, input int imm, input logic dt,
                       input logic [31:0] dtg, input string nm);
    drive(1, 0, 0, pc, k, rd, rs1, imm, 0, 0, 0, 1, 1, dt, dtg, nm);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    drive(0, 0, 0, 32'h0, K_OTHER, 0, 0, 0, 1, pc, t, 1, 0, 0, 0, "upd");
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom % 4)
      0: return 5'd1;
      1: return 5'd5;
      2: return 5'd0;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin : stim
    kind_t       k;
    logic [31:0] pc;
    int          imm;
    int          guard;

    drive(0, 0, 0, 0, K_OTHER, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
    drive(0, 0, 1, 0, K_JAL, 1, 0, 8, 1, 32'h100, 1, 0, 0, 0, 0, "rst");
    drive(0, 0, 0, 32'h1234, K_BR, 0, 0, 16, 0, 0, 0, 1, 1, 0, 32'h1238, "reset_idle");

    fetch(K_BR, 32'h100, 0, 0, 16, 0, 32'h104, "br_init");
    upd(32'h100, 1); upd(32'h100, 1);
    fetch(K_BR, 32'h100, 0, 0, 16, 1, 32'h110, "br_trained");

    repeat (4) upd(32'h304, 1);
    upd(32'h304, 0);
    fetch(K_BR, 32'h304, 0, 0, -8, 1, 32'h2FC, "br_ctr10");
    upd(32'h304, 0); upd(32'h304, 0);
    fetch(K_BR, 32'h304, 0, 0, -8, 0, 32'h308, "br_ctr00");

    fetch(K_JAL, 32'h200, 1, 0, 32'h40, 1, 32'h240, "call");
    fetch(K_JALR, 32'h240, 0, 1, 0, 1, 32'h204, "ret");
    fetch(K_JALR, 32'h244, 0, 1, 0, 0, 32'h248, "ret_empty");

    for (int n = 1; n <= 5; n++)
      fetch(K_JAL, 32'(n * 16), 1, 0, 32'h1000, 1, 32'(n * 16 + 32'h1000), "call_n");
    for (int n = 0; n < 4; n++)
      fetch(K_JALR, 32'h400 + 32'(4 * n), 0, 1, 0, 1, 32'h54 - 32'(16 * n), "ret_n");
    fetch(K_JALR, 32'h410, 0, 1, 0, 0, 32'h414, "ret_n_empty");

    drive(1, 1, 0, 32'h500, K_JAL, 1, 0, 32'h40, 0, 0, 0, 1, 1, 1, 32'h540, "call_stall");
    fetch(K_JALR, 32'h600, 0, 1, 0, 0, 32'h604, "ret_after_stall");
    fetch(K_JAL, 32'h700, 1, 0, 32'h40, 1, 32'h740, "call_pre_flush");
    drive(1, 0, 1, 32'h710, K_JAL, 5, 0, 32'h40, 0, 0, 0, 1, 1, 1, 32'h750, "call_flush");
    fetch(K_JALR, 32'h720, 0, 1, 0, 0, 32'h724, "ret_after_flush");

    drive(1, 0, 0, 32'h808, K_BR, 0, 0, 8, 1, 32'h808, 1, 1, 1, 0, 32'h80C, "same_cyc_old");
    fetch(K_BR, 32'h808, 0, 0, 8, 1, 32'h810, "same_cyc_new");

    for (int n = 0; n < 3000; n++) begin
      k  = kind_t'($urandom % 4);
      pc = ($urandom % 32 == 0) ? 32'hFFFF_F000 + 32'(4 * $urandom_range(0, 1023))
                                : 32'h1000 + 32'(4 * $urandom_range(0, 255));
      imm = (k == K_JAL) ? int'($urandom_range(0, 1048575)) * 2 - 1048576
                         : int'($urandom_range(0, 4095)) * 2 - 4096;
      drive($urandom % 4 != 0, $urandom % 8 == 0, $urandom % 16 == 0, pc, k,
            pick_reg(), pick_reg(), imm, 1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 255)),
            1'($urandom), $urandom % 300 != 0, 0, 0, 0, "rand");
    end

    drive(0, 0, 0, 0, K_OTHER, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "tail");
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
